// File: rtl/rom_pkg.sv
// Shared definitions for the burst ROM reader: default widths and FSM state encoding.
// The optional running-sum output is enabled with the ROM_READER_SUM_EN macro.
package rom_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // The final ROM load of a burst is the one issued while exactly one word remains.
    function automatic logic is_last_load(input logic [ADDR_W_DEF+15:0] remaining);
        return remaining == 1;
    endfunction

endpackage

// File: rtl/rom_reader_if.sv
// Control, ROM-side and stream-side signals of rom_reader bundled as one interface.
// The sum_o wire is present only when ROM_READER_SUM_EN is defined.
interface rom_reader_if
    import rom_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              start_i;
    logic [ADDR_W-1:0] base_i;
    logic [ADDR_W:0]   len_i;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_data_i;
    logic [DATA_W-1:0] dout_o;
    logic              dout_valid_o;
    logic              dout_ready_i;
    logic              busy_o;
    logic              done_o;
`ifdef ROM_READER_SUM_EN
    logic [DATA_W-1:0] sum_o;

    modport slave (
        input  start_i, base_i, len_i, rom_data_i, dout_ready_i,
        output rom_addr_o, dout_o, dout_valid_o, busy_o, done_o, sum_o
    );

    modport master (
        output start_i, base_i, len_i, rom_data_i, dout_ready_i,
        input  rom_addr_o, dout_o, dout_valid_o, busy_o, done_o, sum_o
    );
`else
    modport slave (
        input  start_i, base_i, len_i, rom_data_i, dout_ready_i,
        output rom_addr_o, dout_o, dout_valid_o, busy_o, done_o
    );

    modport master (
        output start_i, base_i, len_i, rom_data_i, dout_ready_i,
        input  rom_addr_o, dout_o, dout_valid_o, busy_o, done_o
    );
`endif

endinterface

// File: rtl/rom_reader.sv
// Burst reader: streams len_i consecutive words of a combinational ROM from base_i over a
// valid/ready port. Defining ROM_READER_SUM_EN adds a per-burst modulo sum output (sum_o).
module rom_reader
    import rom_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    rom_reader_if.slave bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W:0]   rem_q,   rem_d;
    logic [DATA_W-1:0] dout_q,  dout_d;
    logic              valid_q, valid_d;
    logic              done_q,  done_d;
    logic              load;
    logic              beat;
    logic              start_ok;
    logic              last_load;

    // The output register may be refilled whenever it is empty or being drained this cycle.
    assign load      = !valid_q || bus.dout_ready_i;
    assign beat      = valid_q && bus.dout_ready_i;
    assign start_ok  = bus.start_i && (bus.len_i != '0);
    assign last_load = is_last_load({{(ADDR_W_DEF+15-ADDR_W){1'b0}}, rem_q});

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (load && last_load) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (beat) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.busy_o       = (state_q != ST_IDLE);
        bus.rom_addr_o   = addr_q;
        bus.dout_o       = dout_q;
        bus.dout_valid_o = valid_q;
        bus.done_o       = done_q;
    end

    // Datapath next values
    always_comb begin
        addr_d  = addr_q;
        rem_d   = rem_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    if (start_ok) begin
                        addr_d = bus.base_i;
                        rem_d  = bus.len_i;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (load) begin
                    dout_d  = bus.rom_data_i;
                    valid_d = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (beat) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            rem_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

`ifdef ROM_READER_SUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;

    // Every loaded word is eventually accepted, so summing at load time gives the beat sum
    // one cycle before done_o.
    always_comb begin
        sum_d = sum_q;
        if (state_q == ST_IDLE && start_ok) begin
            sum_d = '0;
        end else if (state_q == ST_READ && load) begin
            sum_d = sum_q + bus.rom_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign bus.sum_o = sum_q;
`endif

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader with a behavioural ROM; sum_o is checked when
// ROM_READER_SUM_EN is defined.
module tb_rom_reader;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    rom_reader_if #(.ADDR_W(6), .DATA_W(16)) bus ();

    rom_reader #(.ADDR_W(6), .DATA_W(16)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // ROM contents: words hold 300+address, except the first two locations.
    function automatic logic [15:0] rom_f(input logic [5:0] a);
        case (a)
            6'd0:    return 16'd365;
            6'd1:    return 16'd364;
            default: return 16'd300 + 16'(a);
        endcase
    endfunction

    assign bus.rom_data_i = rom_f(bus.rom_addr_o);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.dout_valid_o), 32'd0);
        check({tag, "_busy"},  32'(bus.busy_o),       32'd0);
        check({tag, "_done"},  32'(bus.done_o),       32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int e1_data [4] = '{365, 364, 302, 303};
        int e2_data [4] = '{362, 363, 365, 364};
        int e2_addr [4] = '{63, 0, 1, 2};

        bus.start_i      = 1'b0;
        bus.base_i       = '0;
        bus.len_i        = '0;
        bus.dout_ready_i = 1'b1;

        // Reset state
        #3;
        check_idle_outputs("rst");
        check("rst_dout", 32'(bus.dout_o),     32'd0);
        check("rst_addr", 32'(bus.rom_addr_o), 32'd0);
        #9;
        rst_i = 1'b0;
        tick();

        // Burst base=0 len=4, ready high
        bus.base_i = 6'd0; bus.len_i = 7'd4; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check("t1_busy",   32'(bus.busy_o),       32'd1);
        check("t1_valid0", 32'(bus.dout_valid_o), 32'd0);
        check("t1_addr0",  32'(bus.rom_addr_o),   32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t1_dout%0d", k),  32'(bus.dout_o),       32'(e1_data[k]));
            check($sformatf("t1_valid%0d", k), 32'(bus.dout_valid_o), 32'd1);
            check($sformatf("t1_done%0d", k),  32'(bus.done_o),       32'd0);
        end
        tick();
        check("t1_done",  32'(bus.done_o),       32'd1);
        check("t1_vend",  32'(bus.dout_valid_o), 32'd0);
        check("t1_bend",  32'(bus.busy_o),       32'd0);
        tick();
        check("t1_done_pulse", 32'(bus.done_o), 32'd0);

        // Wrap: base=62 len=4
        bus.base_i = 6'd62; bus.len_i = 7'd4; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check("t2_addr_start", 32'(bus.rom_addr_o), 32'd62);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t2_dout%0d", k), 32'(bus.dout_o),     32'(e2_data[k]));
            check($sformatf("t2_addr%0d", k), 32'(bus.rom_addr_o), 32'(e2_addr[k]));
        end
        tick();
        check("t2_done", 32'(bus.done_o), 32'd1);
        tick();

        // Back-pressure: base=10 len=3, ready low for 3 cycles after first valid;
        // a start with new base/len during the burst must be ignored
        bus.dout_ready_i = 1'b0;
        bus.base_i = 6'd10; bus.len_i = 7'd3; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check("t3_valid0", 32'(bus.dout_valid_o), 32'd0);
        tick();
        check("t3_first", 32'(bus.dout_o), 32'd310);
        bus.start_i = 1'b1; bus.base_i = 6'd40; bus.len_i = 7'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            bus.start_i = 1'b0;
            check($sformatf("t3_hold_dout%0d", k),  32'(bus.dout_o),       32'd310);
            check($sformatf("t3_hold_valid%0d", k), 32'(bus.dout_valid_o), 32'd1);
            check($sformatf("t3_hold_addr%0d", k),  32'(bus.rom_addr_o),   32'd11);
        end
        bus.dout_ready_i = 1'b1;
        tick();
        check("t3_dout1", 32'(bus.dout_o), 32'd311);
        tick();
        check("t3_dout2", 32'(bus.dout_o), 32'd312);
        check("t3_busy",  32'(bus.busy_o), 32'd1);
        tick();
        check("t3_done",  32'(bus.done_o),       32'd1);
        check("t3_vend",  32'(bus.dout_valid_o), 32'd0);
        check("t3_dkeep", 32'(bus.dout_o),       32'd312);
        tick();

        // Zero-length request
        bus.base_i = 6'd7; bus.len_i = 7'd0; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check("t4_done",  32'(bus.done_o),       32'd1);
        check("t4_valid", 32'(bus.dout_valid_o), 32'd0);
        check("t4_busy",  32'(bus.busy_o),       32'd0);
        tick();
        check_idle_outputs("t4_after");

        // Reset mid-burst base=20 len=8
        bus.base_i = 6'd20; bus.len_i = 7'd8; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick(); tick(); tick();
        check("t5_pre_dout", 32'(bus.dout_o), 32'd322);
        #2;
        rst_i = 1'b1;
        #1;
        check_idle_outputs("t5_rst");
        check("t5_rst_dout", 32'(bus.dout_o),     32'd0);
        check("t5_rst_addr", 32'(bus.rom_addr_o), 32'd0);
`ifdef ROM_READER_SUM_EN
        check("t5_rst_sum", 32'(bus.sum_o), 32'd0);
`endif
        #2;
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_idle_outputs($sformatf("t5_post%0d", k));
        end
        bus.base_i = 6'd5; bus.len_i = 7'd1; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        check("t5_dout",  32'(bus.dout_o),       32'd305);
        check("t5_valid", 32'(bus.dout_valid_o), 32'd1);
        tick();
        check("t5_done",  32'(bus.done_o), 32'd1);
        tick();

`ifdef ROM_READER_SUM_EN
        // Sum of 302+303+304
        bus.base_i = 6'd2; bus.len_i = 7'd3; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check("t6_sum_clr", 32'(bus.sum_o), 32'd0);
        tick(); tick(); tick(); tick();
        check("t6_done", 32'(bus.done_o), 32'd1);
        check("t6_sum",  32'(bus.sum_o),  32'd909);
        tick();
        check("t6_sum_hold", 32'(bus.sum_o), 32'd909);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
